// File: rtl/tx_port_dispatcher.sv
// N-port transmit dispatcher: replicates a flagged 134-bit packet stream onto per-port FIFOs.
// Optional per-port packet counters are built when TX_DISPATCH_STATS_EN is defined.
module tx_port_dispatcher #(
    parameter int unsigned PORT_NUM        = 4,
    parameter int unsigned DATA_W          = 134,
    parameter int unsigned USEDW_W         = 7,
    parameter int unsigned ADMIT_MAX_USEDW = 31
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [DATA_W-1:0]           iv_data,
    input  logic                        i_data_wr,
    input  logic [PORT_NUM-1:0]         iv_outport,
    output logic                        o_data_ready,
    input  logic [PORT_NUM*USEDW_W-1:0] iv_fifo_usedw,
    output logic [PORT_NUM*DATA_W-1:0]  ov_data,
    output logic [PORT_NUM-1:0]         ov_data_wr,
    output logic                        o_frame_err,
    output logic [15:0]                 ov_drop_cnt,
    output logic [PORT_NUM*32-1:0]      ov_pkt_cnt
);

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

    state_e                       state_q, state_d;
    logic [PORT_NUM-1:0]          mask_q, mask_d;
    logic [PORT_NUM*DATA_W-1:0]   data_q, data_d;
    logic [PORT_NUM-1:0]          wr_q, wr_d;
    logic                         err_q, err_d;
    logic [15:0]                  drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0]            word_d;
    logic [PORT_NUM-1:0]          port_room;
    logic [1:0]                   flags;
    logic                         is_head, is_tail, is_first;
    logic                         data_ready, accept, drop_inc;

    assign flags    = iv_data[DATA_W-1 -: 2];
    assign is_head  = flags[0];
    assign is_tail  = (flags == 2'b10);
    assign is_first = (flags == 2'b01);

    always_comb begin
        port_room = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            port_room[k] = (32'(iv_fifo_usedw[k*USEDW_W +: USEDW_W]) <= ADMIT_MAX_USEDW);
        end
    end

    // Only a head with a nonempty bitmap can be held back; unselected ports never block.
    always_comb begin
        data_ready = 1'b1;
        if (state_q == StIdle && is_head && (|iv_outport)) begin
            data_ready = &(port_room | ~iv_outport);
        end
    end

    assign o_data_ready = data_ready;
    assign accept       = i_data_wr & data_ready;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        wr_d     = '0;
        err_d    = 1'b0;
        drop_inc = 1'b0;
        word_d   = iv_data;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (!is_head) begin
                        err_d = 1'b1;
                    end else if (|iv_outport) begin
                        mask_d  = iv_outport;
                        wr_d    = iv_outport;
                        state_d = is_first ? StFwd : StIdle;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = is_first ? StDrop : StIdle;
                    end
                end
                StFwd: begin
                    wr_d = mask_q;
                    if (is_head) begin
                        // Missing tail: close the current packet, lose the new one.
                        word_d[DATA_W-1 -: 2] = 2'b10;
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (is_tail) begin
                        state_d = StIdle;
                    end
                end
                StDrop: begin
                    if (is_head) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (is_tail) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        data_d = data_q;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (wr_d[k]) begin
                data_d[k*DATA_W +: DATA_W] = word_d;
            end
        end
        drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            data_q     <= '0;
            wr_q       <= '0;
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ov_data     = data_q;
    assign ov_data_wr  = wr_q;
    assign o_frame_err = err_q;
    assign ov_drop_cnt = drop_cnt_q;

`ifdef TX_DISPATCH_STATS_EN
    logic [PORT_NUM*32-1:0] pkt_cnt_q, pkt_cnt_d;

    // Counted alongside the strobe; flag bit DATA_W-1 marks tail, single and forced tail.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (wr_d[k] && word_d[DATA_W-1]) begin
                pkt_cnt_d[k*32 +: 32] = pkt_cnt_q[k*32 +: 32] + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign ov_pkt_cnt = pkt_cnt_q;
`else
    assign ov_pkt_cnt = '0;
`endif

endmodule

// File: doc/tx_port_dispatcher.md
# tx_port_dispatcher

Parametrised N-port transmit dispatcher, sitting between the user module and the per-port `interface_output_process` instances in the core clock domain. It accepts one 134-bit packet stream carrying a destination port bitmap and replicates each packet (unicast or multicast) onto the selected port write interfaces. Packets are admitted only when every selected port FIFO has room for a maximum-size frame. It replaces hard-wired per-port outputs from the user module, so the port count is a parameter instead of a fixed four.

## Interface
Parameters:
- `PORT_NUM`, 4: number of output ports, 1..16.
- `DATA_W`, 134: word width; bits [DATA_W-1:DATA_W-2] are frame flags.
- `USEDW_W`, 7: width of each port FIFO used-words count.
- `ADMIT_MAX_USEDW`, 31: a head is admitted to a port only if that port's usedw ≤ this value.

Ports:
- `i_clk` in 1: core clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `iv_data` in DATA_W: input word.
- `i_data_wr` in 1: input word valid.
- `iv_outport` in PORT_NUM: destination bitmap, sampled on head words only.
- `o_data_ready` in→out 1: word accepted this cycle when `i_data_wr & o_data_ready`.
- `iv_fifo_usedw` in PORT_NUM*USEDW_W: per-port FIFO fill; port k occupies [k*USEDW_W +: USEDW_W].
- `ov_data` out PORT_NUM*DATA_W: per-port write data.
- `ov_data_wr` out PORT_NUM: per-port write strobe.
- `o_frame_err` out 1: one-cycle pulse on a framing error.
- `ov_drop_cnt` out 16: count of packets with an empty bitmap; saturates at 16'hFFFF.
- `ov_pkt_cnt` out PORT_NUM*32: per-port transmitted packet counters (see Configuration).

## Operation
- Frame flags: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single-word packet.
- States:
  - IDLE: waiting for a head.
  - FWD: forwarding body words to the latched mask.
  - DROP: discarding the rest of an empty-bitmap packet.
- IDLE with a valid head (01 or 11):
  - Nonzero bitmap: `o_data_ready` = AND over selected ports of (usedw ≤ ADMIT_MAX_USEDW). Unselected ports are ignored.
  - On acceptance: latch `iv_outport` into the mask and write the word to every selected port. Flag 01 → FWD; flag 11 → stay in IDLE.
  - Zero bitmap: ready=1, word discarded, `ov_drop_cnt`+1. Flag 01 → DROP; flag 11 → stay in IDLE.
- IDLE with a valid non-head word (00 or 10): ready=1, word discarded, `o_frame_err` pulse.
- FWD: ready=1 unconditionally. Each accepted word is written to the latched mask. A tail → IDLE.
- FWD receiving a head (01 or 11), i.e. a missing tail:
  - The word is written to the latched mask with its flags forced to 2'b10 (truncating the packet).
  - `o_frame_err` pulses and the state returns to IDLE; the new packet is lost.
- DROP: ready=1, words discarded. A tail or a head → IDLE; a head here also pulses `o_frame_err`.
- `iv_outport` is ignored on all non-head words and in FWD/DROP.

## Timing
- `o_data_ready` is combinational from state, `iv_data` flags, `iv_outport` and `iv_fifo_usedw`.
- `ov_data` and `ov_data_wr` are registered: an accepted word appears exactly 1 cycle later, with identical data (except a forced tail) on all selected ports.
- `ov_data` holds its last value when the strobe is low.
- Back-to-back single-word packets to different ports are accepted on consecutive cycles.
- Reset values: state IDLE, mask 0, `ov_data` 0, `ov_data_wr` 0, `o_frame_err` 0, `ov_drop_cnt` 0, `ov_pkt_cnt` 0.
- Reset mid-packet abandons the packet with no further strobes. Downstream is reset with the same signal.

## Configuration
- `TX_DISPATCH_STATS_EN` defined: each `ov_pkt_cnt` lane increments by 1 in the cycle its port is written with a tail or single flag, including forced tails. Counters wrap at 2^32.
- Not defined: the counters are not built and `ov_pkt_cnt` is tied to 0. All other behaviour is unchanged.

## Test plan
- Unicast: 4-word packet to bitmap 4'b0010, all usedw=0. Expect ready high throughout; `ov_data_wr`=4'b0010 for 4 cycles, 1 cycle after each accept; data bit-identical.
- Multicast backpressure: head to 4'b0101 with port2 usedw=32. Expect ready=0 while the head is held. Port2 usedw→31: accepted the next cycle and written to ports 0 and 2 only.
- Empty bitmap: 3-word packet with bitmap 0. Expect no strobes and `ov_drop_cnt`=1. A following single-word packet to 4'b1000 is forwarded.
- Missing tail: head, body, then a new head while in FWD. Expect the third word written with flags 2'b10, `o_frame_err` for one cycle, state IDLE.
- Orphan body word in IDLE: expect the word discarded, `o_frame_err` pulse, no strobe. With the macro defined, 3 unicast packets to port1 → `ov_pkt_cnt` lane1=3, other lanes 0.
- Asynchronous reset asserted mid-FWD: all outputs 0 immediately. After release, a body word gives `o_frame_err` and no write.
